uart_tx: RTL and testbench
==========================

# uart_tx

Byte-oriented UART transmitter: the transmit-direction counterpart of `uart_rx` in the UART actuator path. It accepts bytes from the controlling logic through a valid/ready handshake into a small FIFO and serialises each one as an 8N1 frame: one start bit (0), 8 data bits LSB first, and one stop bit (1). The bit period is a parameter. The default of one clock per bit matches `uart_rx`, so the two blocks can be looped back directly in simulation.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 1: clock cycles per serial bit; legal range 1..65535.
- `FIFO_DEPTH`, default 4: transmit FIFO entries; must be a power of two, at least 2.

Ports:
- `clk`, input, 1: single clock; all logic is on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `txbyte`, input, 8: byte to transmit.
- `txstart`, input, 1: request to enqueue `txbyte`.
- `txready`, output, 1: FIFO can accept a byte this cycle.
- `tx`, output, 1: serial line; idles high.
- `txbusy`, output, 1: a frame is in progress or the FIFO is non-empty.
- `txdone`, output, 1: one-cycle pulse after each stop bit completes.

## Operation
- Enqueue happens on a rising edge where `txstart && txready`.
- `txready` is a registered form of "FIFO not full".
  - `txstart` while `txready` is 0 is ignored; the byte is dropped and the FIFO is not overwritten.
  - A push on a full FIFO is refused even if a pop occurs on the same edge.
- FSM states are IDLE, START, DATA, STOP.
  - **IDLE:** `tx`=1. If the FIFO is non-empty, pop the head into the shift register, clear the bit counter, and go to START.
  - **START:** `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - **DATA:** `tx`=shift[0] for `CLKS_PER_BIT` cycles per bit. After each bit, shift right and increment the bit index. After bit 7, go to STOP.
  - **STOP:** `tx`=1 for `CLKS_PER_BIT` cycles, then pulse `txdone`. If the FIFO is non-empty, pop and go straight to START with no idle gap; otherwise go to IDLE.
- Baud counter:
  - 16 bits wide.
  - Loads `CLKS_PER_BIT-1` on entry to each bit and decrements to 0.
  - The bit boundary is reached when the counter is 0. With `CLKS_PER_BIT`=1 every cycle is a boundary.
- Bit index is 3 bits wide and wraps only by a state change, never arithmetically.
- The FIFO pointers are log2(`FIFO_DEPTH`)+1 bits wide.
  - Full: MSBs differ and the low bits are equal.
  - Empty: pointers are equal.
  - Wrap-around is natural modulo 2·`FIFO_DEPTH`.
- `txbusy` = (state != IDLE) || !empty.
- Reset, asserted asynchronously at any time including mid-frame:
  - `tx`=1, state=IDLE, FIFO emptied, `txready`=1, `txbusy`=0, `txdone`=0, counters 0.
  - A partially sent frame is abandoned; the line simply returns high.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Reset values: `tx`=1, `txready`=1, `txbusy`=0, `txdone`=0.
- Latency, idle case: on accept edge N the byte enters the FIFO. The start bit drives `tx` from edge N+1. Data bit k starts at edge N+1+(k+1)·`CLKS_PER_BIT`. The stop bit starts at edge N+1+9·`CLKS_PER_BIT`.
- `txdone` is high for exactly one cycle, starting at edge N+1+10·`CLKS_PER_BIT`.
- The frame length is exactly 10·`CLKS_PER_BIT` cycles.
- Back-to-back frames: the next start bit begins on the same edge that `txdone` rises.
- `txready` deasserts on the edge after the push that fills the FIFO. It reasserts on the edge after the pop.

## Structure
- Package `uart_pkg` holds:
  - the `uart_tx_state_t` enum (IDLE, START, DATA, STOP);
  - the constants `UART_DATA_BITS`=8, `UART_START_LVL`=0, `UART_STOP_LVL`=1.
- `uart_pkg` is shared with `uart_rx`.
- Sub-module `uart_tx_fifo` is a synchronous FIFO parameterised by `FIFO_DEPTH` with width 8.
  - Ports: push, pop, din, dout, full, empty.
  - It uses the same `clk`/`rst_n`.
- The FSM, baud counter and shift register live in `uart_tx`.

## Test plan
- **Reset values:** hold reset for 3 cycles, then release. Expect `tx`=1, `txready`=1, `txbusy`=0, `txdone`=0 throughout, with no activity.
- **Single byte 'G' (0x47), `CLKS_PER_BIT`=1:** send one byte. Expect `tx` = 0,1,1,1,0,0,0,1,0,1 on consecutive cycles starting one cycle after acceptance, then `txdone` high for one cycle, then idle.
- **Loopback:** connect `tx` to the `rx` of `uart_rx` and send 'G' then 'b' (0x62). Expect `rxbyte` = 0x47 then 0x62 with one `rxdone` each, and the two frames back-to-back with no gap.
- **FIFO full:** with `FIFO_DEPTH`=4 and `CLKS_PER_BIT`=1, assert `txstart` for 6 consecutive cycles with 0x41..0x46. Expect:
  - `txready` low before the 6th push;
  - frames for 0x41..0x45 only, with 0x46 dropped;
  - 5 `txdone` pulses.
- **Baud scaling, `CLKS_PER_BIT`=4:** send 0xA5. Expect each bit held for exactly 4 cycles, bits LSB first 1,0,1,0,0,1,0,1, and a total frame of 40 cycles.
- **Reset mid-frame:** assert `rst_n`=0 during data bit 3 with 2 bytes queued. Expect:
  - `tx`=1 immediately, asynchronously, and the FIFO empty;
  - after release, no further frames.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and frame-level constants.
// Used by both the transmit and receive blocks.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [7:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: bytes are queued in a small FIFO and serialised
// LSB first with one start and one stop bit, CLKS_PER_BIT clocks per bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] txbyte,
    input  logic       txstart,
    output logic       txready,
    output logic       tx,
    output logic       txbusy,
    output logic       txdone
);

    localparam logic [15:0] BAUD_LOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t state_q, state_d;
    logic [15:0]    baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           done_q, done_d;

    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [7:0]     fifo_dout;
    logic           boundary;

    uart_tx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (txstart && txready),
        .pop  (fifo_pop),
        .din  (txbyte),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign boundary = (baud_q == 16'd0);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = UART_STOP_LVL;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    bit_d    = 3'd0;
                    baud_d   = BAUD_LOAD;
                    tx_d     = UART_START_LVL;
                    state_d  = START;
                end
            end
            START: begin
                if (boundary) begin
                    baud_d  = BAUD_LOAD;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            DATA: begin
                if (boundary) begin
                    baud_d = BAUD_LOAD;
                    if (bit_q == LAST_BIT) begin
                        tx_d    = UART_STOP_LVL;
                        state_d = STOP;
                    end else begin
                        // tx is registered, so drive the bit that is about to be shifted down.
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            STOP: begin
                if (boundary) begin
                    done_d = 1'b1;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        bit_d    = 3'd0;
                        baud_d   = BAUD_LOAD;
                        tx_d     = UART_START_LVL;
                        state_d  = START;
                    end else begin
                        baud_d  = 16'd0;
                        tx_d    = UART_STOP_LVL;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                tx_d    = UART_STOP_LVL;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= UART_STOP_LVL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx      = tx_q;
    assign txdone  = done_q;
    assign txready = !fifo_full;
    assign txbusy  = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: two instances (1 and 4 clocks per bit) checked
// every cycle against a frame-schedule model of the transmitter.
module tb_uart_tx;

    localparam int DEPTH = 4;
    localparam int MAXF  = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n1, rst_n4;
    logic       txstart1, txstart4;
    logic [7:0] txbyte1, txbyte4;
    logic       txready1, tx1, txbusy1, txdone1;
    logic       txready4, tx4, txbusy4, txdone4;

    uart_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst_n(rst_n1), .txbyte(txbyte1), .txstart(txstart1),
        .txready(txready1), .tx(tx1), .txbusy(txbusy1), .txdone(txdone1)
    );

    uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(DEPTH)) dut4 (
        .clk(clk), .rst_n(rst_n4), .txbyte(txbyte4), .txstart(txstart4),
        .txready(txready4), .tx(tx4), .txbusy(txbusy4), .txdone(txdone4)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: each accepted byte gets an accept edge and a frame start edge.
    int         f_n [2];
    int         f_acc [2][MAXF];
    int         f_start [2][MAXF];
    logic [7:0] f_byte [2][MAXF];

    function automatic int cpb(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int pending(input int d, input int t);
        int c;
        c = 0;
        for (int i = 0; i < f_n[d]; i++)
            if (f_acc[d][i] <= t && f_start[d][i] > t) c++;
        return c;
    endfunction

    function automatic logic in_frame(input int d, input int t);
        logic v;
        v = 1'b0;
        for (int i = 0; i < f_n[d]; i++)
            if (t >= f_start[d][i] && t < f_start[d][i] + 10 * cpb(d)) v = 1'b1;
        return v;
    endfunction

    function automatic logic exp_tx(input int d, input int t);
        logic v;
        int   b;
        v = 1'b1;
        for (int i = 0; i < f_n[d]; i++) begin
            if (t >= f_start[d][i] && t < f_start[d][i] + 10 * cpb(d)) begin
                b = (t - f_start[d][i]) / cpb(d);
                if (b == 0)      v = 1'b0;
                else if (b <= 8) v = f_byte[d][i][b-1];
                else             v = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic exp_done(input int d, input int t);
        logic v;
        v = 1'b0;
        for (int i = 0; i < f_n[d]; i++)
            if (t == f_start[d][i] + 10 * cpb(d)) v = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] exp_vec(input int d, input int t);
        return {exp_tx(d, t), exp_done(d, t),
                in_frame(d, t) || (pending(d, t) > 0), pending(d, t) < DEPTH};
    endfunction

    task automatic model_clear(input int d);
        f_n[d] = 0;
    endtask

    // Drive one cycle of stimulus on instance d and let the model decide acceptance.
    task automatic step(input int d, input logic go, input logic [7:0] b);
        int   last_end;
        logic rst_ok;
        if (d == 0) begin txstart1 = go; txbyte1 = b; end
        else        begin txstart4 = go; txbyte4 = b; end
        rst_ok = (d == 0) ? rst_n1 : rst_n4;
        @(posedge clk);
        cyc++;
        if (go && rst_ok && pending(d, cyc - 1) < DEPTH && f_n[d] < MAXF) begin
            last_end = (f_n[d] == 0) ? 0 : f_start[d][f_n[d]-1] + 10 * cpb(d);
            f_acc[d][f_n[d]]   = cyc;
            f_start[d][f_n[d]] = (cyc + 1 > last_end) ? cyc + 1 : last_end;
            f_byte[d][f_n[d]]  = b;
            f_n[d]++;
        end
        #1;
        txstart1 = 1'b0;
        txstart4 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n1 = 1'b0;
        rst_n4 = 1'b0;
        repeat (3) begin
            @(posedge clk);
            cyc++;
            #1;
            n_checks += 2;
            if ({tx1, txready1, txbusy1, txdone1} !== 4'b1100) begin
                n_fail++;
                $display("[TB] FAIL reset_dut1 {tx,ready,busy,done} got=%b exp=1100", {tx1, txready1, txbusy1, txdone1});
            end
            if ({tx4, txready4, txbusy4, txdone4} !== 4'b1100) begin
                n_fail++;
                $display("[TB] FAIL reset_dut4 {tx,ready,busy,done} got=%b exp=1100", {tx4, txready4, txbusy4, txdone4});
            end
        end
        rst_n1 = 1'b1;
        rst_n4 = 1'b1;
        repeat (6) begin
            step(0, 1'b0, 8'h00);
            n_checks += 2;
            if ({tx1, txready1, txbusy1, txdone1} !== 4'b1100) begin
                n_fail++;
                $display("[TB] FAIL post_reset_dut1 got=%b exp=1100", {tx1, txready1, txbusy1, txdone1});
            end
            if ({tx4, txready4, txbusy4, txdone4} !== 4'b1100) begin
                n_fail++;
                $display("[TB] FAIL post_reset_dut4 got=%b exp=1100", {tx4, txready4, txbusy4, txdone4});
            end
        end
    endtask

    task automatic test_single_byte();
        logic [9:0] seq;
        seq = '0;
        model_clear(0);
        step(0, 1'b1, 8'h47);
        for (int i = 1; i <= 14; i++) begin
            if (i > 1 || i == 1) begin
                step(0, 1'b0, 8'h00);
            end
            if (i <= 10) seq = {seq[8:0], tx1};
            n_checks++;
            if ({tx1, txdone1, txbusy1, txready1} !== exp_vec(0, cyc)) begin
                n_fail++;
                $display("[TB] FAIL single_byte cyc=%0d {tx,done,busy,ready} got=%b exp=%b", cyc, {tx1, txdone1, txbusy1, txready1}, exp_vec(0, cyc));
            end
            if (i == 11) begin
                n_checks++;
                if (txdone1 !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL single_byte_done got=%b exp=1", txdone1);
                end
            end
        end
        n_checks++;
        if (seq !== 10'b0111000101) begin
            n_fail++;
            $display("[TB] FAIL single_byte_frame got=%b exp=0111000101", seq);
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        int first_done_tx;
        dones = 0;
        first_done_tx = -1;
        model_clear(0);
        step(0, 1'b1, 8'h47);
        step(0, 1'b1, 8'h62);
        for (int i = 0; i < 30; i++) begin
            step(0, 1'b0, 8'h00);
            if (txdone1 === 1'b1) begin
                if (dones == 0) first_done_tx = int'(tx1);
                dones++;
            end
            n_checks++;
            if ({tx1, txdone1, txbusy1, txready1} !== exp_vec(0, cyc)) begin
                n_fail++;
                $display("[TB] FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, {tx1, txdone1, txbusy1, txready1}, exp_vec(0, cyc));
            end
        end
        n_checks += 2;
        if (dones !== 2) begin
            n_fail++;
            $display("[TB] FAIL back_to_back_dones got=%0d exp=2", dones);
        end
        if (first_done_tx !== 0) begin
            n_fail++;
            $display("[TB] FAIL back_to_back_gap tx_at_done got=%0d exp=0", first_done_tx);
        end
    endtask

    task automatic test_fifo_full();
        int dones;
        dones = 0;
        model_clear(0);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                n_checks++;
                if (txready1 !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL fifo_full_ready got=%b exp=0", txready1);
                end
            end
            step(0, 1'b1, 8'(8'h41 + i));
            if (txdone1 === 1'b1) dones++;
            n_checks++;
            if ({tx1, txdone1, txbusy1, txready1} !== exp_vec(0, cyc)) begin
                n_fail++;
                $display("[TB] FAIL fifo_full_fill cyc=%0d got=%b exp=%b", cyc, {tx1, txdone1, txbusy1, txready1}, exp_vec(0, cyc));
            end
        end
        for (int i = 0; i < 60; i++) begin
            step(0, 1'b0, 8'h00);
            if (txdone1 === 1'b1) dones++;
            n_checks++;
            if ({tx1, txdone1, txbusy1, txready1} !== exp_vec(0, cyc)) begin
                n_fail++;
                $display("[TB] FAIL fifo_full_drain cyc=%0d got=%b exp=%b", cyc, {tx1, txdone1, txbusy1, txready1}, exp_vec(0, cyc));
            end
        end
        n_checks++;
        if (dones !== 5) begin
            n_fail++;
            $display("[TB] FAIL fifo_full_dones got=%0d exp=5", dones);
        end
    endtask

    task automatic test_baud_scaling();
        logic [9:0]  ts;
        logic [39:0] exp40;
        logic [39:0] obs40;
        int          acc_cyc;
        int          done_cyc;
        ts = 10'b0101001011;
        exp40 = '0;
        obs40 = '0;
        done_cyc = -1;
        for (int k = 0; k < 10; k++)
            for (int r = 0; r < 4; r++) exp40 = {exp40[38:0], ts[9-k]};
        model_clear(1);
        step(1, 1'b1, 8'hA5);
        acc_cyc = cyc;
        for (int i = 1; i <= 46; i++) begin
            step(1, 1'b0, 8'h00);
            if (i <= 40) obs40 = {obs40[38:0], tx4};
            if (txdone4 === 1'b1 && done_cyc < 0) done_cyc = cyc;
            n_checks++;
            if ({tx4, txdone4, txbusy4, txready4} !== exp_vec(1, cyc)) begin
                n_fail++;
                $display("[TB] FAIL baud cyc=%0d got=%b exp=%b", cyc, {tx4, txdone4, txbusy4, txready4}, exp_vec(1, cyc));
            end
        end
        n_checks += 2;
        if (obs40 !== exp40) begin
            n_fail++;
            $display("[TB] FAIL baud_frame got=%h exp=%h", obs40, exp40);
        end
        if (done_cyc !== acc_cyc + 41) begin
            n_fail++;
            $display("[TB] FAIL baud_frame_len done_at=%0d exp=%0d", done_cyc, acc_cyc + 41);
        end
        for (int j = 0; j < 4; j++) begin
            step(1, 1'b1, 8'($urandom));
            for (int g = 0; g < int'($urandom_range(0, 60)); g++) begin
                step(1, 1'b0, 8'h00);
                n_checks++;
                if ({tx4, txdone4, txbusy4, txready4} !== exp_vec(1, cyc)) begin
                    n_fail++;
                    $display("[TB] FAIL baud_random cyc=%0d got=%b exp=%b", cyc, {tx4, txdone4, txbusy4, txready4}, exp_vec(1, cyc));
                end
            end
        end
        for (int i = 0; i < 200; i++) begin
            step(1, 1'b0, 8'h00);
            n_checks++;
            if ({tx4, txdone4, txbusy4, txready4} !== exp_vec(1, cyc)) begin
                n_fail++;
                $display("[TB] FAIL baud_drain cyc=%0d got=%b exp=%b", cyc, {tx4, txdone4, txbusy4, txready4}, exp_vec(1, cyc));
            end
        end
    endtask

    task automatic test_random();
        model_clear(0);
        for (int i = 0; i < 300; i++) begin
            step(0, $urandom_range(0, 99) < 40, 8'($urandom));
            n_checks++;
            if ({tx1, txdone1, txbusy1, txready1} !== exp_vec(0, cyc)) begin
                n_fail++;
                $display("[TB] FAIL random cyc=%0d got=%b exp=%b", cyc, {tx1, txdone1, txbusy1, txready1}, exp_vec(0, cyc));
            end
        end
        for (int i = 0; i < 60; i++) begin
            step(0, 1'b0, 8'h00);
            n_checks++;
            if ({tx1, txdone1, txbusy1, txready1} !== exp_vec(0, cyc)) begin
                n_fail++;
                $display("[TB] FAIL random_drain cyc=%0d got=%b exp=%b", cyc, {tx1, txdone1, txbusy1, txready1}, exp_vec(0, cyc));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int acc_cyc;
        int dones;
        dones = 0;
        model_clear(1);
        step(1, 1'b1, 8'($urandom) & 8'hF7);
        acc_cyc = cyc;
        step(1, 1'b1, 8'($urandom));
        step(1, 1'b1, 8'($urandom));
        while (cyc < acc_cyc + 18) begin
            step(1, 1'b0, 8'h00);
            n_checks++;
            if ({tx4, txdone4, txbusy4, txready4} !== exp_vec(1, cyc)) begin
                n_fail++;
                $display("[TB] FAIL midreset_pre cyc=%0d got=%b exp=%b", cyc, {tx4, txdone4, txbusy4, txready4}, exp_vec(1, cyc));
            end
        end
        n_checks++;
        if (tx4 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midreset_bit3 got=%b exp=0", tx4);
        end
        #2;
        rst_n4 = 1'b0;
        #1;
        model_clear(1);
        n_checks++;
        if ({tx4, txready4, txbusy4, txdone4} !== 4'b1100) begin
            n_fail++;
            $display("[TB] FAIL midreset_async {tx,ready,busy,done} got=%b exp=1100", {tx4, txready4, txbusy4, txdone4});
        end
        repeat (3) step(1, 1'b0, 8'h00);
        rst_n4 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step(1, 1'b0, 8'h00);
            if (txdone4 === 1'b1) dones++;
            n_checks++;
            if ({tx4, txdone4, txbusy4, txready4} !== exp_vec(1, cyc)) begin
                n_fail++;
                $display("[TB] FAIL midreset_post cyc=%0d got=%b exp=%b", cyc, {tx4, txdone4, txbusy4, txready4}, exp_vec(1, cyc));
            end
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("[TB] FAIL midreset_dones got=%0d exp=0", dones);
        end
    endtask

    initial begin
        f_n[0]   = 0;
        f_n[1]   = 0;
        txstart1 = 1'b0;
        txstart4 = 1'b0;
        txbyte1  = 8'h00;
        txbyte4  = 8'h00;
        rst_n1   = 1'b0;
        rst_n4   = 1'b0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_fifo_full();
        test_baud_scaling();
        test_random();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
